// File: rtl/icmp_rx.sv
// ICMP receive parser: checks length, type/code and the optional checksum (`ICMP_RX_CHECKSUM_EN`),
// then emits one verdict pulse per frame, four cycles after the last byte.
module icmp_rx #(
    parameter logic [15:0] P_MAX_LEN = 16'd1480,
    parameter logic [15:0] P_MIN_LEN = 16'd8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_icmp_data,
    input  logic        i_icmp_valid,
    input  logic        i_icmp_last,
    output logic        o_trig_reply,
    output logic [15:0] o_trig_seq,
    output logic        o_reply_rcv,
    output logic [15:0] o_reply_seq,
    output logic        o_drop
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

    state_t      state, state_nxt;
    logic [15:0] r_cnt;
    logic [7:0]  typ, code, seq_hi, seq_lo;
    logic [7:0]  typ_cur, code_cur, seq_hi_cur, seq_lo_cur;
    logic        beat_last;
    logic        ovl;
    logic        short_len;
    logic        csum_ok;

    logic        vld_p0, vld_p1, vld_p2;
    logic [32:0] meta_p0, meta_p1, meta_p2;

    assign beat_last = i_icmp_valid & i_icmp_last;
    assign short_len = (r_cnt + 16'd1) < P_MIN_LEN;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_icmp_valid) begin
            case (state)
                IDLE: state_nxt = i_icmp_last ? IDLE : HDR;
                HDR: begin
                    if (i_icmp_last)         state_nxt = IDLE;
                    else if (r_cnt == 16'd7) state_nxt = DATA;
                end
                DATA: begin
                    if (i_icmp_last)                        state_nxt = IDLE;
                    else if (r_cnt == P_MAX_LEN - 16'd1)    state_nxt = DROP;
                end
                DROP: if (i_icmp_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ovl = (state == DROP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          r_cnt <= 16'd0;
        else if (i_icmp_valid) r_cnt <= i_icmp_last ? 16'd0 : r_cnt + 16'd1;
    end

    // Header fields; the current byte is forwarded so an 8-byte frame sees its own seq low byte.
    always_ff @(posedge i_clk) begin
        if (i_icmp_valid) begin
            if (r_cnt == 16'd0) typ    <= i_icmp_data;
            if (r_cnt == 16'd1) code   <= i_icmp_data;
            if (r_cnt == 16'd6) seq_hi <= i_icmp_data;
            if (r_cnt == 16'd7) seq_lo <= i_icmp_data;
        end
    end

    assign typ_cur    = (r_cnt == 16'd0) ? i_icmp_data : typ;
    assign code_cur   = (r_cnt == 16'd1) ? i_icmp_data : code;
    assign seq_hi_cur = (r_cnt == 16'd6) ? i_icmp_data : seq_hi;
    assign seq_lo_cur = (r_cnt == 16'd7) ? i_icmp_data : seq_lo;

`ifdef ICMP_RX_CHECKSUM_EN
    logic [7:0]  hi_byte;
    logic [31:0] acc, acc_nxt;
    logic [31:0] sum_p0, sum_p1, sum_p2;

    function automatic logic [31:0] fold(input logic [31:0] s);
        return {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
    endfunction

    always_comb begin
        acc_nxt = acc;
        if (r_cnt[0])         acc_nxt = acc + {16'h0000, hi_byte, i_icmp_data};
        else if (i_icmp_last) acc_nxt = acc + {16'h0000, i_icmp_data, 8'h00};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= 32'd0;
            hi_byte <= 8'd0;
        end else if (i_icmp_valid) begin
            if (!r_cnt[0]) hi_byte <= i_icmp_data;
            acc <= i_icmp_last ? 32'd0 : acc_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (beat_last) sum_p0 <= acc_nxt;
        sum_p1 <= fold(sum_p0);
        sum_p2 <= fold(sum_p1);
    end

    assign csum_ok = (sum_p2 == 32'h0000_FFFF);
`else
    assign csum_ok = 1'b1;
`endif

    // p0: frame summary captured on the last beat
    always_ff @(posedge i_clk) begin
        if (beat_last)
            meta_p0 <= {short_len | ovl, typ_cur, code_cur, seq_hi_cur, seq_lo_cur};
        meta_p1 <= meta_p0;
        meta_p2 <= meta_p1;
    end

    // p1/p2: fold stages; valid flushes on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= beat_last;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Verdict stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_trig_reply <= 1'b0;
            o_reply_rcv  <= 1'b0;
            o_drop       <= 1'b0;
            o_trig_seq   <= 16'd0;
            o_reply_seq  <= 16'd0;
        end else begin
            o_trig_reply <= 1'b0;
            o_reply_rcv  <= 1'b0;
            o_drop       <= 1'b0;
            if (vld_p2) begin
                if (meta_p2[32] || !csum_ok) begin
                    o_drop <= 1'b1;
                end else if (meta_p2[31:16] == 16'h0800) begin
                    o_trig_reply <= 1'b1;
                    o_trig_seq   <= meta_p2[15:0];
                end else if (meta_p2[31:16] == 16'h0000) begin
                    o_reply_rcv  <= 1'b1;
                    o_reply_seq  <= meta_p2[15:0];
                end else begin
                    o_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icmp_rx.sv
// Scoreboard bench for icmp_rx: directed frames push expected verdicts, a monitor pops and checks them.
module tb_icmp_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        o_trig_reply, o_reply_rcv, o_drop;
    logic [15:0] o_trig_seq, o_reply_seq;

    icmp_rx dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_icmp_data (data),
        .i_icmp_valid(valid),
        .i_icmp_last (last),
        .o_trig_reply(o_trig_reply),
        .o_trig_seq  (o_trig_seq),
        .o_reply_rcv (o_reply_rcv),
        .o_reply_seq (o_reply_seq),
        .o_drop      (o_drop)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 drop, 1 trigger, 2 reply received
        logic [15:0] seq;
        longint      due;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_trig = 16'h0;
    logic [15:0] m_reply = 16'h0;
    int          np, ak;
    exp_t        e;

`ifdef ICMP_RX_CHECKSUM_EN
    localparam int BAD_CSUM_KIND = 0;
`else
    localparam int BAD_CSUM_KIND = 1;
`endif

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mk_echo(input logic [7:0] t, input logic [15:0] cs, input logic [15:0] seq,
                           input int len);
        fb.delete();
        fb.push_back(t);        fb.push_back(8'h00);
        fb.push_back(cs[15:8]); fb.push_back(cs[7:0]);
        fb.push_back(8'h00);    fb.push_back(8'h01);
        fb.push_back(seq[15:8]); fb.push_back(seq[7:0]);
        while (fb.size() < len) fb.push_back(8'h00);
    endtask

    task automatic send(input int kind, input logic [15:0] seq, input int gap);
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            data  = fb[i];
            last  = (i == fb.size() - 1);
            if (last) sb.push_back('{kind, seq, cyc + 4});
            if (gap > 0 && (i % 3) == 1 && !last) begin
                @(posedge clk); #1;
                valid = 1'b0;
                data  = 8'hEE;
                last  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid = 1'b0;
            last  = 1'b0;
            data  = 8'h5A;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_trig  = 16'h0;
            m_reply = 16'h0;
        end else begin
            if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("missing_pulse_cycle", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            np = int'(o_trig_reply) + int'(o_reply_rcv) + int'(o_drop);
            if (np != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", np, 0);
                end else begin
                    e  = sb.pop_front();
                    ak = (np > 1) ? 3 : o_trig_reply ? 1 : o_reply_rcv ? 2 : 0;
                    chk("verdict_kind", ak, e.kind);
                    chk("verdict_cycle", cyc, e.due);
                    if (e.kind == 1) m_trig = e.seq;
                    if (e.kind == 2) m_reply = e.seq;
                    chk("trig_seq", o_trig_seq, m_trig);
                    chk("reply_seq", o_reply_seq, m_reply);
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trig_reply", o_trig_reply, 0);
        chk("rst_reply_rcv", o_reply_rcv, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_trig_seq", o_trig_seq, 0);
        chk("rst_reply_seq", o_reply_seq, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // basic 40-byte echo request
        mk_echo(8'h08, 16'hF7F9, 16'h0005, 40);
        send(1, 16'h0005, 0);
        idle(8);

        // wrong checksum
        mk_echo(8'h08, 16'hF7F8, 16'h0005, 40);
        send(BAD_CSUM_KIND, 16'h0005, 0);
        idle(8);

        // odd length with padded final byte, with bubbles
        mk_echo(8'h08, 16'h4CF9, 16'h0005, 41);
        fb[40] = 8'hAB;
        send(1, 16'h0005, 1);
        idle(8);

        // request then reply, zero gap
        mk_echo(8'h08, 16'hF7FD, 16'h0001, 40);
        send(1, 16'h0001, 0);
        mk_echo(8'h00, 16'hFFF7, 16'h0007, 40);
        send(2, 16'h0007, 0);
        idle(8);

        // 6-byte short frame
        mk_echo(8'h08, 16'hF7F9, 16'h0005, 8);
        void'(fb.pop_back());
        void'(fb.pop_back());
        send(0, 16'h0, 0);
        idle(4);

        // 1-byte frame
        fb.delete();
        fb.push_back(8'h08);
        send(0, 16'h0, 0);
        idle(4);

        // minimum-length request (seq low byte is the last byte)
        mk_echo(8'h08, 16'hF7F9, 16'h0005, 8);
        send(1, 16'h0005, 0);
        idle(6);

        // unknown type with valid checksum
        mk_echo(8'h0D, 16'hF2F9, 16'h0005, 8);
        send(0, 16'h0, 0);
        idle(6);

        // exactly maximum length accepted, then overlength dropped
        mk_echo(8'h08, 16'hF7F9, 16'h0005, 1480);
        send(1, 16'h0005, 0);
        idle(6);
        mk_echo(8'h08, 16'hF7F9, 16'h0005, 1490);
        send(0, 16'h0, 0);
        idle(8);

        // reset in the middle of a request
        mk_echo(8'h08, 16'hF7F9, 16'h0033, 40);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            data  = fb[i];
            last  = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        last  = 1'b1;
        @(negedge clk);
        chk("midrst_trig_seq", o_trig_seq, 0);
        chk("midrst_drop", o_drop, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        idle(6);
        mk_echo(8'h08, 16'hF7F5, 16'h0009, 40);
        send(1, 16'h0009, 0);
        idle(8);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icmp_rx.md
# icmp_rx

Receive-side ICMP parser between the IP receive layer and `ICMP_TX`. It consumes the ICMP message bytes forwarded by the IP layer, whose IP header is already stripped and protocol is 1, and validates length, type/code and checksum. For an echo request it emits a one-cycle reply trigger with the sequence number, which drives `ICMP_TX` `i_trig_reply`/`i_trig_seq`. It also reports received echo replies and dropped messages.

## Interface
Parameters:
- `P_MAX_LEN`, default 16'd1480: maximum accepted ICMP message length in bytes.
- `P_MIN_LEN`, default 16'd8: minimum length, i.e. the ICMP echo header.

Ports:
- `i_clk`, in, 1: the single clock; all logic is clocked on its rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_icmp_data`, in, 8: message byte; byte 0 is the type.
- `i_icmp_valid`, in, 1: byte qualifier. Bubbles are allowed within a frame.
- `i_icmp_last`, in, 1: marks the final byte; qualified by `i_icmp_valid`.
- `o_trig_reply`, out, 1: one-cycle pulse when a valid echo request (type 8, code 0) is received.
- `o_trig_seq`, out, 16: sequence number of the last accepted request; held until the next request.
- `o_reply_rcv`, out, 1: one-cycle pulse when a valid echo reply (type 0, code 0) is received.
- `o_reply_seq`, out, 16: sequence number of the last accepted reply; held.
- `o_drop`, out, 1: one-cycle pulse when a message is discarded.

## Operation
- A byte counter `r_cnt` (16 bit) increments on each valid byte and clears on the last byte. Bytes 0/1 are latched as type/code, bytes 6/7 as sequence {hi, lo}.
- FSM states:
  - IDLE: the first valid byte moves to HDR, with `r_cnt`=1 after it.
  - HDR: on a valid byte with `r_cnt`==7, move to DATA. A last byte with `r_cnt`<7 is a short frame: return to IDLE and flag a drop.
  - DATA: a last byte returns to IDLE. A valid, non-last byte with `r_cnt`==`P_MAX_LEN`-1 moves to DROP.
  - DROP: absorb bytes until the last byte, then return to IDLE and flag a drop.
  - A last byte in IDLE (1-byte frame) is a short frame: stay in IDLE and flag a drop.
- Checksum accumulator, 32 bit:
  - An even-index byte is held as the high byte.
  - On the odd-index byte, add {hi, lo}.
  - If the last byte has an even index (odd length), add {byte, 8'h00}.
  - The accumulator starts from 0 at each frame.
- Verdict pipeline (3 stages, independent of the FSM), loaded on the last beat with:
  - the final sum;
  - type, code and sequence;
  - the short/overlength flags.
- Pipeline arithmetic: two fold stages, each computing `sum[31:16]+sum[15:0]`; the final stage compares the folded value against 16'hFFFF.
- Verdict priority:
  1. Length error gives `o_drop`.
  2. Checksum error gives `o_drop`.
  3. Type 8 / code 0 gives `o_trig_reply` and updates `o_trig_seq`.
  4. Type 0 / code 0 gives `o_reply_rcv` and updates `o_reply_seq`.
  5. Any other type/code gives `o_drop`.
- Exactly one of the three pulses fires per frame.
- Because the FSM returns to IDLE on the last beat, back-to-back frames with zero gap are supported, and each frame gets its own verdict.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters and accumulators are 0. While reset is asserted all inputs are ignored.
- Reset mid-frame: the partial frame is lost with no pulse. A verdict already in the pipeline is flushed. The first valid byte after reset release is treated as byte 0.
- Latency: if the last beat is in cycle L, the verdict pulse is high in cycle L+4 only.
- Verdict latency is identical for all outcomes and is unchanged by configuration.
- `o_trig_seq`/`o_reply_seq` change in the same cycle as their pulse.
- `i_icmp_valid` low holds all state; bytes presented without valid are ignored.

## Configuration
- `ICMP_RX_CHECKSUM_EN` defined: the checksum is verified, and a mismatch gives `o_drop`.
- `ICMP_RX_CHECKSUM_EN` undefined:
  - the accumulator logic is removed and the checksum is treated as always good;
  - the pipeline depth and the L+4 latency are kept.

## Test plan
- 40-byte echo request (08 00 F7 F9 00 01 00 05, then zeros) -> `o_trig_reply`=1 at L+4 only, `o_trig_seq`=16'h0005, `o_drop`=0.
- Same frame with checksum F7F8, macro defined -> `o_drop` pulse at L+4, no trigger, `o_trig_seq` unchanged. With the macro undefined -> trigger with seq 0005.
- 41-byte request with seq 0005, checksum 4CF9 and final byte AB -> `o_trig_reply` pulse, which proves the odd-length padding.
- Echo reply 00 00 FF F7 00 01 00 07 plus 32 zeros, back-to-back with zero gap after a request with seq 0001 (checksum F7FD) -> `o_trig_reply` with seq 0001 at L1+4, then `o_reply_rcv` with seq 0007 at L2+4.
- 6-byte frame -> `o_drop` at L+4. A `P_MAX_LEN`+10 byte frame -> `o_drop` once, 4 cycles after its last byte.
- `i_rst_n` pulsed low at byte 20 of a request, then a clean request with seq 0009 -> no pulse for the first frame; `o_trig_reply` with seq 0009 for the second.
